dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 22 ++
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder and its word array.
package dmem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Number of index bits needed to address depth words (depth is a power of two).
    function automatic int idx_width(input int depth);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << w) < depth) w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM with registered read data; no reset logic.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH_WORDS = 256,
    localparam int IDX_W       = idx_width(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  index,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[index] <= wdata;
        rdata <= mem[index];
    end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the CPU load/store port.
// Optional request error checking is enabled with `define DMEM_ERR_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata
`ifdef DMEM_ERR_EN
    ,
    output logic              rsp_err
`endif
);

    // Handshake: a request is taken on a rising edge where req_valid && req_ready.
    // req_ready decodes IDLE only; rsp_valid is a one-cycle pulse with no backpressure.

    localparam int         IDX_W    = idx_width(DEPTH_WORDS);
    localparam int         LAST_I   = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
    localparam logic [3:0] CNT_LAST = LAST_I[3:0];

    state_t              state_q, state_d;
    logic [3:0]          cnt_q;
    logic                lat_write_q;
    logic [IDX_W-1:0]    lat_idx_q;
    logic [WORD_W-1:0]   lat_wdata_q;
    logic [WORD_W-1:0]   hold_q;
    logic [WORD_W-1:0]   arr_rdata;

    logic                accept;
    logic                enter_resp;
    logic                arr_we;
    logic                addr_bad;
    logic                cur_write;
    logic                cur_err;
    logic [IDX_W-1:0]    cur_idx;
    logic [WORD_W-1:0]   cur_wdata;
    logic                resp_zero;

    assign addr_bad = (req_addr[1:0] != 2'b00) || ((req_addr >> (IDX_W + 2)) != '0);

`ifdef DMEM_ERR_EN
    logic lat_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      lat_err_q <= 1'b0;
        else if (accept) lat_err_q <= addr_bad;
    end

    assign cur_err   = (state_q == IDLE) ? addr_bad : lat_err_q;
    assign resp_zero = lat_write_q || lat_err_q;
    assign rsp_err   = (state_q == RESP) && lat_err_q;
`else
    logic unused_addr_bad;
    assign unused_addr_bad = addr_bad;
    assign cur_err   = 1'b0;
    assign resp_zero = lat_write_q;
`endif

    // With zero wait states the array is accessed on the acceptance edge itself,
    // so the live request must bypass the latch while still in IDLE.
    assign cur_write = (state_q == IDLE) ? req_write : lat_write_q;
    assign cur_idx   = (state_q == IDLE) ? req_addr[IDX_W+1:2] : lat_idx_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata : lat_wdata_q;

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) state_d = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign enter_resp = (state_d == RESP) && (state_q != RESP);
    assign arr_we     = enter_resp && cur_write && !cur_err && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            lat_write_q <= 1'b0;
            lat_idx_q   <= '0;
            lat_wdata_q <= '0;
            hold_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q       <= 4'd0;
                lat_write_q <= req_write;
                lat_idx_q   <= req_addr[IDX_W+1:2];
                lat_wdata_q <= req_wdata;
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q + 4'd1;
            end
            if (state_q == RESP) hold_q <= rsp_rdata;
        end
    end

    // Outside the pulse the last response data is held.
    always_comb begin
        rsp_rdata = hold_q;
        if (state_q == RESP) rsp_rdata = resp_zero ? '0 : arr_rdata;
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .index (cur_idx),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: table vectors, corner sequences and
// randomized traffic against a word-array reference model.
module tb_dmem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 256;
    localparam int P     = W + 2;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        req_valid, req_ready, req_write, rsp_valid, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;

    logic        req_valid0, req_ready0, req_write0, rsp_valid0, rsp_err0;
    logic [31:0] req_addr0, req_wdata0, rsp_rdata0;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mem_m [int];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t tbl[8];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
`ifdef DMEM_ERR_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid0),
        .req_ready (req_ready0),
        .req_write (req_write0),
        .req_addr  (req_addr0),
        .req_wdata (req_wdata0),
        .rsp_valid (rsp_valid0),
        .rsp_rdata (rsp_rdata0)
`ifdef DMEM_ERR_EN
        ,
        .rsp_err   (rsp_err0)
`endif
    );

`ifndef DMEM_ERR_EN
    assign rsp_err  = 1'b0;
    assign rsp_err0 = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: memory of words addressed modulo DEPTH, plus the error rules.
    function automatic void model_step(input logic w, input logic [31:0] a, input logic [31:0] d,
                                       output logic [31:0] rd, output logic er, output bit known);
        int idx;
        idx   = int'(a[31:2]) % DEPTH;
        er    = 1'b0;
`ifdef DMEM_ERR_EN
        er    = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
`endif
        rd    = 32'd0;
        known = 1'b1;
        if (!er) begin
            if (w) mem_m[idx] = d;
            else if (mem_m.exists(idx)) rd = mem_m[idx];
            else known = 1'b0;
        end
    endfunction

    // Entered just after a negedge with the DUT idle; returns one cycle after the pulse.
    task automatic run_xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic er);
        int lat;
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
        lat = 1;
        while (!rsp_valid && lat <= W + 4) begin
            req_valid = 1'($urandom);
            req_write = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            @(negedge clk);
            lat++;
        end
        req_valid = 1'b0;
        rd = rsp_rdata;
        er = rsp_err;
        chk("latency", 32'(lat), 32'(W + 1));
        @(negedge clk);
        chk("pulse_once", 32'(rsp_valid), 32'd0);
        chk("ready_back", 32'(req_ready), 32'd1);
        chk("rdata_hold", rsp_rdata, rd);
    endtask

    task automatic run0(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd);
        req_valid0 = 1'b1;
        req_write0 = w;
        req_addr0  = a;
        req_wdata0 = d;
        @(negedge clk);
        req_valid0 = 1'b0;
        chk("w0_rsp_valid", 32'(rsp_valid0), 32'd1);
        chk("w0_ready_low", 32'(req_ready0), 32'd0);
        chk("w0_rdata", rsp_rdata0, exp_rd);
        @(negedge clk);
        chk("w0_ready_back", 32'(req_ready0), 32'd1);
        chk("w0_pulse_once", 32'(rsp_valid0), 32'd0);
    endtask

    initial begin
        logic [31:0] rd, mrd, a;
        logic        er, mer;
        bit          known;
        int          cnt;

        tbl[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0};
        tbl[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2] = '{1'b1, 32'h0000_0000, 32'h0000_5555, 32'h0, 1'b0};
`ifdef DMEM_ERR_EN
        tbl[3] = '{1'b1, 32'h0000_0400, 32'h0000_1234, 32'h0, 1'b1};
        tbl[4] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_5555, 1'b0};
        tbl[5] = '{1'b0, 32'h0000_0003, 32'h0,         32'h0, 1'b1};
        tbl[6] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0, 1'b0};
        tbl[7] = '{1'b0, 32'h0000_07FC, 32'h0,         32'h0, 1'b1};
`else
        tbl[3] = '{1'b1, 32'h0000_0400, 32'h0000_1234, 32'h0, 1'b0};
        tbl[4] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_1234, 1'b0};
        tbl[5] = '{1'b0, 32'h0000_0003, 32'h0,         32'h0000_1234, 1'b0};
        tbl[6] = '{1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0, 1'b0};
        tbl[7] = '{1'b0, 32'h0000_07FC, 32'h0,         32'hCAFE_F00D, 1'b0};
`endif

        rst_n = 1'b0;
        {req_valid, req_write, req_addr, req_wdata} = '0;
        {req_valid0, req_write0, req_addr0, req_wdata0} = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_rdata0", rsp_rdata0, 32'd0);
`ifdef DMEM_ERR_EN
        chk("rst_err", 32'(rsp_err), 32'd0);
`endif

        for (int i = 0; i < 8; i++) begin
            run_xact(tbl[i].w, tbl[i].a, tbl[i].d, rd, er);
            model_step(tbl[i].w, tbl[i].a, tbl[i].d, mrd, mer, known);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
`ifdef DMEM_ERR_EN
            chk($sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].exp_er));
`endif
        end

        // Zero-wait-state instance: store then load word 0.
        run0(1'b1, 32'h0, 32'h0000_0077, 32'h0);
        run0(1'b0, 32'h0, 32'h0, 32'h0000_0077);

        // Reset in WAIT drops a pending store.
        run_xact(1'b1, 32'h20, 32'h1111_1111, rd, er);
        model_step(1'b1, 32'h20, 32'h1111_1111, mrd, mer, known);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5_A5A5;
        @(negedge clk);
        req_valid = 1'b0;
        chk("wait_ready_low", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstw_ready", 32'(req_ready), 32'd1);
        chk("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) cnt++;
        end
        chk("rstw_no_rsp", 32'(cnt), 32'd0);
        run_xact(1'b0, 32'h20, 32'h0, rd, er);
        chk("rstw_old_data", rd, 32'h1111_1111);

        // Throughput with req_valid held high and the address changing every cycle.
        for (int i = 0; i < 8; i++) begin
            run_xact(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i * 32'h111), rd, er);
            model_step(1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i * 32'h111), mrd, mer, known);
        end
        exp_q.delete();
        for (int c = 0; c < 3 * P; c++) begin
            a = 32'($urandom_range(0, 7)) << 2;
            req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_wdata = $urandom;
            chk("tp_ready", 32'(req_ready), 32'((c % P) == 0));
            chk("tp_rsp_valid", 32'(rsp_valid), 32'((c % P) == P - 1));
            if ((c % P) == 0) exp_q.push_back(mem_m[int'(a[31:2])]);
            if (rsp_valid) begin
                if (exp_q.size() == 0) chk("tp_unexpected_rsp", 32'd1, 32'd0);
                else chk("tp_rdata", rsp_rdata, exp_q.pop_front());
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("tp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Randomized traffic over a small window, including aliased and misaligned addresses.
        for (int n = 0; n < 40; n++) begin
            logic w;
            logic [31:0] d;
            w = 1'($urandom);
            d = $urandom;
            a = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 3) == 0) a = a + 32'h400;
            if ($urandom_range(0, 5) == 0) a = a + 32'($urandom_range(1, 3));
            run_xact(w, a, d, rd, er);
            model_step(w, a, d, mrd, mer, known);
            if (known) chk($sformatf("rnd%0d_rdata", n), rd, mrd);
`ifdef DMEM_ERR_EN
            chk($sformatf("rnd%0d_err", n), 32'(er), 32'(mer));
`endif
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
